// File: rtl/tm1638_disp.sv
// Decimal display back-end for an 8-digit TM1638 module: captures a 16-bit value,
// converts it to BCD, encodes 7-segment patterns and writes a full frame on STB/CLK/DIO.
module tm1638_disp #(
  parameter int         CLK_DIV = 50,
  parameter logic [2:0] BRIGHT  = 3'd7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bin,
  input  logic        bin_valid,
  output logic        busy,
  output logic        STB,
  output logic        CLK,
  inout  wire         DIO
);
  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, CONV, ENC, G1, GAP, G2, G3} state_t;
  typedef enum logic [1:0] {PH_LEAD, PH_LOW, PH_HIGH, PH_TAIL} phase_t;

  state_t           state_reg, state_next;
  phase_t           phase_reg, phase_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [2:0]       bit_reg, bit_next;
  logic [4:0]       byte_reg, byte_next;
  logic [3:0]       step_reg, step_next;
  logic [35:0]      dd_reg, dd_next;
  logic [63:0]      seg_reg, seg_next;
  logic             stb_reg, stb_next;
  logic             sclk_reg, sclk_next;
  logic             dio_reg, dio_next;
  logic             busy_reg, busy_next;

  logic             accept;
  logic             in_group;
  logic             slot_end;
  logic [19:0]      bcd_adj;
  logic [35:0]      dd_step;
  logic [63:0]      seg_enc;
  logic [7:0]       cur_byte;
  logic [7:0]       adv_byte;
  logic [4:0]       last_byte;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'h3F;
      4'd1:    seg7 = 8'h06;
      4'd2:    seg7 = 8'h5B;
      4'd3:    seg7 = 8'h4F;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'h6D;
      4'd6:    seg7 = 8'h7D;
      4'd7:    seg7 = 8'h07;
      4'd8:    seg7 = 8'h7F;
      4'd9:    seg7 = 8'h6F;
      default: seg7 = 8'h00;
    endcase
  endfunction

  // Byte idx of the current group; in G2 idx 0 is the address command, idx k is RAM address k-1.
  function automatic logic [7:0] frame_byte(input state_t st, input logic [4:0] idx,
                                            input logic [63:0] segs);
    logic [4:0] addr;
    addr       = idx - 5'd1;
    frame_byte = 8'h00;
    case (st)
      G1: frame_byte = 8'h40;
      G2: begin
        if (idx == 5'd0)
          frame_byte = 8'hC0;
        else if (!addr[0])
          frame_byte = segs[{addr[3:1], 3'b000} +: 8];
      end
      G3:      frame_byte = {5'b10001, BRIGHT};
      default: frame_byte = 8'h00;
    endcase
  endfunction

  for (genvar gi = 0; gi < 5; gi++) begin : g_dabble
    assign bcd_adj[4*gi +: 4] = (dd_reg[16+4*gi +: 4] >= 4'd5) ?
                                dd_reg[16+4*gi +: 4] + 4'd3 : dd_reg[16+4*gi +: 4];
  end
  assign dd_step = {bcd_adj[18:0], dd_reg[15:0], 1'b0};

  // Digit gi (gi=0 is units) lands on grid 8-gi; a digit is blank when it and every higher digit are zero.
  for (genvar gi = 0; gi < 5; gi++) begin : g_digit
    logic [3:0] digit;
    assign digit = dd_reg[16+4*gi +: 4];
    if (gi == 0) begin : g_units
      assign seg_enc[8*(7-gi) +: 8] = seg7(digit);
    end else begin : g_upper
      assign seg_enc[8*(7-gi) +: 8] = (|dd_reg[35:16+4*gi]) ? seg7(digit) : 8'h00;
    end
  end
  assign seg_enc[23:0] = '0;

  assign accept    = bin_valid && !busy_reg;
  assign in_group  = (state_reg == G1) || (state_reg == G2) || (state_reg == G3) || (state_reg == GAP);
  assign slot_end  = in_group && (div_reg == DIV_LAST);
  assign last_byte = (state_reg == G2) ? 5'd16 : 5'd0;
  assign cur_byte  = frame_byte(state_reg, byte_reg, seg_reg);
  assign adv_byte  = frame_byte(state_reg, byte_reg + 5'd1, seg_reg);

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    div_next   = '0;
    bit_next   = bit_reg;
    byte_next  = byte_reg;
    step_next  = step_reg;
    dd_next    = dd_reg;
    seg_next   = seg_reg;
    stb_next   = stb_reg;
    sclk_next  = sclk_reg;
    dio_next   = dio_reg;
    busy_next  = accept || (state_reg != IDLE);
    if (in_group)
      div_next = slot_end ? '0 : div_reg + DIV_W'(1);

    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = CONV;
          dd_next    = {20'd0, bin};
          step_next  = 4'd0;
        end
      end
      CONV: begin
        dd_next   = dd_step;
        step_next = step_reg + 4'd1;
        if (step_reg == 4'd15)
          state_next = ENC;
      end
      ENC: begin
        seg_next   = seg_enc;
        state_next = G1;
        phase_next = PH_LEAD;
        bit_next   = 3'd0;
        byte_next  = 5'd0;
        stb_next   = 1'b0;
      end
      // Two half-period slots with STB high; byte_reg still tells which group came before.
      GAP: begin
        if (slot_end) begin
          if (phase_reg == PH_LOW) begin
            phase_next = PH_HIGH;
          end else begin
            state_next = (byte_reg == 5'd0) ? G2 : G3;
            phase_next = PH_LEAD;
            bit_next   = 3'd0;
            byte_next  = 5'd0;
            stb_next   = 1'b0;
          end
        end
      end
      default: begin
        if (slot_end) begin
          case (phase_reg)
            PH_LEAD: begin
              phase_next = PH_LOW;
              sclk_next  = 1'b0;
              dio_next   = cur_byte[0];
            end
            PH_LOW: begin
              phase_next = PH_HIGH;
              sclk_next  = 1'b1;
            end
            PH_HIGH: begin
              if (bit_reg == 3'd7 && byte_reg == last_byte) begin
                phase_next = PH_TAIL;
              end else begin
                phase_next = PH_LOW;
                sclk_next  = 1'b0;
                if (bit_reg == 3'd7) begin
                  bit_next  = 3'd0;
                  byte_next = byte_reg + 5'd1;
                  dio_next  = adv_byte[0];
                end else begin
                  bit_next = bit_reg + 3'd1;
                  dio_next = cur_byte[bit_reg + 3'd1];
                end
              end
            end
            default: begin
              stb_next = 1'b1;
              dio_next = 1'b1;
              if (state_reg == G3) begin
                state_next = IDLE;
              end else begin
                state_next = GAP;
                phase_next = PH_LOW;
              end
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      phase_reg <= PH_LEAD;
      div_reg   <= '0;
      bit_reg   <= 3'd0;
      byte_reg  <= 5'd0;
      step_reg  <= 4'd0;
      dd_reg    <= '0;
      seg_reg   <= '0;
      stb_reg   <= 1'b1;
      sclk_reg  <= 1'b1;
      dio_reg   <= 1'b1;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      div_reg   <= div_next;
      bit_reg   <= bit_next;
      byte_reg  <= byte_next;
      step_reg  <= step_next;
      dd_reg    <= dd_next;
      seg_reg   <= seg_next;
      stb_reg   <= stb_next;
      sclk_reg  <= sclk_next;
      dio_reg   <= dio_next;
      busy_reg  <= busy_next;
    end
  end

  assign busy = busy_reg;
  assign STB  = stb_reg;
  assign CLK  = sclk_reg;
  assign DIO  = dio_reg;
endmodule

// File: doc/tm1638_disp.md
# tm1638_disp

Display back-end that consumes the 16-bit binary result word (`bin`) produced by the I2C front-end and shows it in decimal on an 8-digit TM1638 module. On each accepted update it converts the value to BCD (sequential double-dabble), encodes 7-segment patterns and writes a full display frame over the TM1638 three-wire bus (STB/CLK/DIO). It sits directly downstream of the I2C acquisition logic inside the top level.

## Interface
- `CLK_DIV`, 50: `clk` cycles per TM1638 CLK half-period (D). With a 100 MHz `clk` this gives a 1 MHz bus clock. Minimum value is 2.
- `BRIGHT`, 3'd7: brightness field of the display-control command.
- `clk`  in  1  system clock; the only clock domain.
- `rst`  in  1  synchronous, active-low reset.
- `bin`  in  16  unsigned value to display.
- `bin_valid`  in  1  one-cycle load strobe.
- `busy`  out  1  high from the cycle after acceptance until the frame is complete.
- `STB`  out  1  TM1638 strobe, active low.
- `CLK`  out  1  TM1638 serial clock. The device samples DIO on the rising edge.
- `DIO`  inout  1  TM1638 data. Driven continuously by this block; key-scan readback is not supported.

## Operation
- Reset values: `busy`=0, `STB`=1, `CLK`=1, `DIO`=1. All counters and the FSM are cleared.
- Accept rule: `bin` is captured when `bin_valid`=1 and `busy`=0 in the same cycle. A `bin_valid` pulse while `busy`=1 is dropped; no queueing.
- FSM states: IDLE → CONV (16 cycles of shift-add-3 on a 20-bit BCD plus 16-bit shift register) → ENC (1 cycle) → G1 → GAP → G2 → GAP → G3 → IDLE.
- Segment encoding is common-cathode, bit0=a … bit6=g, dp=0:
  - digits 0–9 map to 3F 06 5B 4F 66 6D 7D 07 7F 6F;
  - blank is 00.
- Digit layout:
  - the value is right-aligned, with the units digit on grid 8 (address 0xCE);
  - grids 1–3 are always blank;
  - leading zeros are blanked, except that the units digit always shows.
- Frame content:
  - G1 sends 0x40 (write, auto-increment).
  - G2 sends 0xC0, then 16 data bytes for addresses 0x00..0x0F. Even addresses carry the segment code for grids 1..8. Odd addresses (LEDs) carry 0x00.
  - G3 sends 0x88 | BRIGHT.
- Byte serialisation is LSB first, 8 bits per byte. Bytes inside a group are contiguous, with no extra gap.

## Timing
- The acceptance edge is cycle 0. `busy`=1 from cycle 1.
- The first STB fall occurs at cycle 18 (1 capture + 16 CONV + 1 ENC).
- Group shape:
  - STB falls;
  - D cycles of lead time with CLK=1;
  - then the bits;
  - after the last bit's high phase, D cycles of tail, then STB rises.
- Bit cell (2D cycles):
  - CLK goes low and DIO updates in the same cycle;
  - CLK stays low for D cycles, then high for D cycles.
  - DIO is stable for the whole cell, so it is stable across the rising edge.
- GAP: STB=1 and CLK=1 for 2D cycles.
- Group lengths: G1 = 18D, G2 = 274D, G3 = 18D.
- The first STB fall to the last STB rise spans 314D cycles exactly.
- `busy` falls the cycle after the final STB rise. A new `bin_valid` is accepted in that same cycle.
- Idle DIO level: held at 1 whenever STB=1.
- Reset asserted mid-frame (any state): on the next edge `STB`=`CLK`=`DIO`=1 and `busy`=0. The partial frame is abandoned; STB rising aborts it in the device.
- Reset and `bin_valid` in the same cycle: reset wins and nothing is captured.
- Widths:
  - BCD register is 20 bits; 65535 fits in 5 digits.
  - Bit counter is 3 bits and byte counter is 5 bits.
  - Divider counter is $clog2(CLK_DIV) bits. It wraps at CLK_DIV−1 and is held at 0 in IDLE.

## Test plan
- Basic frame, CLK_DIV=4: load 1234 → decoded bytes are 40; C0, then 00 on all grids except grids 5–8 = 06 5B 4F 66 (odd addresses 00); then 8F. STB-low-to-STB-high span is 1256 cycles, and the first STB fall is at cycle 18.
- Zero: load 0 → grid 8 = 3F, all other grids 00.
- Maximum: load 65535 → grids 4–8 = 7D 6D 6D 4F 6D, grids 1–3 = 00.
- Handshake:
  - load 42, then pulse `bin_valid` with 9999 mid-frame → dropped; the frame shows 42.
  - Pulse 7 in the cycle `busy` falls → accepted, and the next frame shows grid 8 = 07.
- Reset mid-G2: assert `rst`=0 for 1 cycle → next edge has STB/CLK/DIO=1 and `busy`=0. A following load of 5 produces a complete, correct frame.
- Bit-level check, CLK_DIV=4: verify the 0x40 bit pattern (LSB first: 0,0,0,0,0,0,1,0). DIO must not change within 4 cycles before or after any CLK rising edge. Verify the 8-cycle high gap between groups.
